// File: rtl/decode_pkg.sv
// Shared types and the index-to-lines decode function for decode_nm_pipe.
package decode_pkg;

    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT   = 256;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } dec_mode_t;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic               err;
        logic [MAX_OUT-1:0] code;
    } dec_res_t;

    // Out-of-range wins over en; lines at or above num_out always stay zero.
    function automatic dec_res_t dec_fn(input logic [MAX_SEL_W-1:0] sel,
                                        input logic                 en,
                                        input dec_mode_t            mode,
                                        input int unsigned          num_out);
        dec_res_t res;
        res = '0;
        if (32'(sel) >= num_out) begin
            res.err = 1'b1;
        end else if (en) begin
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (mode == MODE_ONEHOT) res.code[i] = (i == 32'(sel));
                else                     res.code[i] = (i <= 32'(sel));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry valid/ready register stage: output register plus one skid slot.
module decode_skid
    import decode_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state, state_n;
    logic [W-1:0] out_q, out_n, skid_q, skid_n;
    logic         valid_q, ready_q;
    logic         accept, drain;

    assign accept = in_valid && ready_q;
    assign drain  = valid_q && out_ready;

    // Next-state and data steering; the skid slot only fills when the output is stalled.
    always_comb begin
        state_n = state;
        out_n   = out_q;
        skid_n  = skid_q;
        case (state)
            SK_EMPTY: begin
                if (accept) begin
                    state_n = SK_ONE;
                    out_n   = in_data;
                end
            end
            SK_ONE: begin
                if (accept && drain) begin
                    out_n = in_data;
                end else if (accept) begin
                    state_n = SK_TWO;
                    skid_n  = in_data;
                end else if (drain) begin
                    state_n = SK_EMPTY;
                end
            end
            SK_TWO: begin
                if (drain) begin
                    state_n = SK_ONE;
                    out_n   = skid_q;
                end
            end
            default: state_n = SK_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SK_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            out_q   <= out_n;
            skid_q  <= skid_n;
            valid_q <= (state_n != SK_EMPTY);
            ready_q <= (state_n != SK_TWO);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/decode_nm_pipe.sv
// Pipelined binary-to-N-line decoder (one-hot / thermometer) with valid/ready skid output.
module decode_nm_pipe
    import decode_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_en,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_code,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int unsigned PW = NUM_OUT + 1;

    if (SEL_W < 1 || SEL_W > MAX_SEL_W || NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_params
        $error("decode_nm_pipe: illegal SEL_W/NUM_OUT combination");
    end

    dec_res_t      res;
    logic [PW-1:0] in_data, out_data;
    logic          unused_res;

    assign res        = dec_fn(MAX_SEL_W'(in_sel), in_en, dec_mode_t'(in_mode), NUM_OUT);
    assign unused_res = &{1'b0, res};
    assign in_data    = {res.err, res.code[NUM_OUT-1:0]};

    decode_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_err  = out_data[NUM_OUT];
    assign out_code = out_data[NUM_OUT-1:0];

    // Saturating count of accepted out-of-range beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (in_valid && in_ready && res.err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_nm_pipe.sv
// Bench for decode_nm_pipe: queue-based reference model, per-cycle compare, directed literal checks.
module tb_decode_nm_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_en, in_mode, out_ready;
    logic [2:0] in_sel;

    logic       in_ready, out_valid, out_err;
    logic [7:0] out_code, err_cnt;
    logic       in_ready6, out_valid6, out_err6;
    logic [5:0] out_code6;
    logic [1:0] err_cnt6;

    always #5 clk = ~clk;

    decode_nm_pipe #(.SEL_W(3), .NUM_OUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_en(in_en), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    decode_nm_pipe #(.SEL_W(3), .NUM_OUT(6), .CNT_W(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in_sel(in_sel), .in_en(in_en), .in_mode(in_mode),
        .out_valid(out_valid6), .out_ready(out_ready), .out_code(out_code6),
        .out_err(out_err6), .err_cnt(err_cnt6)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Reference: {err, code} from the decode rules using plain shifts.
    function automatic logic [8:0] expect_beat(input int sel, input bit en, input bit mode, input int n_out);
        logic [8:0] r;
        r = '0;
        if (sel >= n_out) r[8] = 1'b1;
        else if (en) r[7:0] = mode ? 8'((1 << (sel + 1)) - 1) : 8'(1 << sel);
        return r;
    endfunction

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    // Model: each DUT holds at most two beats in FIFO order.
    logic [8:0] q8[$];
    logic [8:0] q6[$];
    int cnt8 = 0;
    int cnt6 = 0;

    initial begin
        bit         acc8, acc6, drn8, drn6;
        logic [8:0] b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q8.delete(); q6.delete(); cnt8 = 0; cnt6 = 0;
            end else begin
                acc8 = in_valid && (q8.size() < 2);
                acc6 = in_valid && (q6.size() < 2);
                drn8 = (q8.size() > 0) && out_ready;
                drn6 = (q6.size() > 0) && out_ready;
                if (drn8) void'(q8.pop_front());
                if (drn6) void'(q6.pop_front());
                if (acc8) begin
                    b = expect_beat(int'(in_sel), in_en, in_mode, 8);
                    q8.push_back(b);
                    if (b[8]) cnt8++;
                end
                if (acc6) begin
                    b = expect_beat(int'(in_sel), in_en, in_mode, 6);
                    q6.push_back(b);
                    if (b[8]) cnt6++;
                end
            end
        end
    end

    // Per-cycle compare just after each rising edge; also logs completed beats.
    logic [8:0] got8[$];
    logic [8:0] got6[$];
    int   ncomp = 0;
    logic p_valid = 1'b0, p_err = 1'b0, p_valid6 = 1'b0, p_err6 = 1'b0;
    logic [7:0] p_code = '0;
    logic [5:0] p_code6 = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                p_valid = 1'b0; p_valid6 = 1'b0;
            end else begin
                if (p_valid && out_ready) begin
                    got8.push_back({p_err, p_code});
                    ncomp++;
                end else if (p_valid) begin
                    chk("hold8", 32'({out_valid, out_err, out_code}), 32'({1'b1, p_err, p_code}));
                end
                if (p_valid6 && out_ready) got6.push_back({p_err6, 2'b00, p_code6});
                else if (p_valid6)
                    chk("hold6", 32'({out_valid6, out_err6, out_code6}), 32'({1'b1, p_err6, p_code6}));
                chk("valid8", 32'(out_valid), 32'(q8.size() > 0));
                chk("ready8", 32'(in_ready), 32'(q8.size() < 2));
                chk("cnt8", 32'(err_cnt), 32'(sat(cnt8, 255)));
                if (q8.size() > 0) chk("beat8", 32'({out_err, out_code}), 32'(q8[0]));
                chk("valid6", 32'(out_valid6), 32'(q6.size() > 0));
                chk("ready6", 32'(in_ready6), 32'(q6.size() < 2));
                chk("cnt6", 32'(err_cnt6), 32'(sat(cnt6, 3)));
                if (q6.size() > 0) chk("beat6", 32'({out_err6, 2'b00, out_code6}), 32'(q6[0]));
                p_valid = out_valid; p_err = out_err; p_code = out_code;
                p_valid6 = out_valid6; p_err6 = out_err6; p_code6 = out_code6;
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        got8.delete(); got6.delete(); ncomp = 0;
    endtask

    task automatic send(input int sel, input bit en, input bit mode);
        int n;
        n = 0;
        in_valid = 1'b1; in_sel = 3'(sel); in_en = en; in_mode = mode;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((q8.size() != 0 || q6.size() != 0) && n < 100) begin @(negedge clk); n++; end
        chk(name, 32'(q8.size() + q6.size()), 32'd0);
        @(negedge clk);
    endtask

    logic [7:0] t1_exp [8];

    initial begin
        int  n, sent, cyc;
        bit  acc_next;
        t1_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        in_valid = 1'b0; in_sel = '0; in_en = 1'b1; in_mode = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_code", 32'({out_err, out_code}), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back one-hot, one cycle latency, no bubbles.
        for (int s = 0; s < 8; s++) begin
            chk("t1_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1; in_sel = 3'(s); in_en = 1'b1; in_mode = 1'b0;
            @(negedge clk);
            chk("t1_lat", 32'({out_valid, out_code}), 32'({1'b1, t1_exp[s]}));
        end
        in_valid = 1'b0;
        wait_empty("t1_drain");
        chk("t1_count", 32'(got8.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < got8.size()) chk("t1_seq", 32'(got8[i]), 32'({1'b0, t1_exp[i]}));

        // Thermometer and enable-off.
        do_reset();
        send(3, 1'b1, 1'b1);
        send(7, 1'b1, 1'b1);
        send(5, 1'b0, 1'b1);
        wait_empty("t2_drain");
        chk("t2_count", 32'(got8.size()), 32'd3);
        if (got8.size() == 3) begin
            chk("t2_therm3", 32'(got8[0]), 32'h00F);
            chk("t2_therm7", 32'(got8[1]), 32'h0FF);
            chk("t2_en0", 32'(got8[2]), 32'h000);
        end
        if (got6.size() == 3) chk("t2_n6_sel7", 32'(got6[1]), 32'h100);
        else chk("t2_count6", 32'(got6.size()), 32'd3);

        // Out-of-range on a 6-line decoder, then counter saturation.
        do_reset();
        send(6, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        wait_empty("t3_drain");
        chk("t3_cnt6", 32'(err_cnt6), 32'd2);
        chk("t3_cnt8", 32'(err_cnt), 32'd0);
        if (got6.size() == 2) begin
            chk("t3_err6a", 32'(got6[0]), 32'h100);
            chk("t3_err6b", 32'(got6[1]), 32'h100);
        end else chk("t3_count6", 32'(got6.size()), 32'd2);
        if (got8.size() == 2) chk("t3_n8_sel7", 32'(got8[1]), 32'h080);
        send(6, 1'b1, 1'b1);
        send(7, 1'b0, 1'b0);
        send(6, 1'b1, 1'b0);
        wait_empty("t3_drain2");
        chk("t3_sat", 32'(err_cnt6), 32'd3);

        // Backpressure fills the skid slot, then drains in order.
        do_reset();
        out_ready = 1'b0;
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        in_valid = 1'b1; in_sel = 3'd3; in_en = 1'b1; in_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_ready", 32'(in_ready), 32'd0);
            chk("t4_hold", 32'({out_valid, out_code}), 32'h102);
            @(negedge clk);
        end
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("t4_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_empty("t4_drain");
        chk("t4_count", 32'(got8.size()), 32'd3);
        if (got8.size() == 3) begin
            chk("t4_b0", 32'(got8[0]), 32'h002);
            chk("t4_b1", 32'(got8[1]), 32'h004);
            chk("t4_b2", 32'(got8[2]), 32'h008);
        end

        // Random valid/ready traffic.
        do_reset();
        sent = 0; cyc = 0; acc_next = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (acc_next) begin sent++; in_valid = 1'b0; end
            if (!in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_sel   = 3'($urandom_range(0, 7));
                in_en    = ($urandom_range(0, 7) != 0);
                in_mode  = 1'($urandom_range(0, 1));
            end
            acc_next  = in_valid && in_ready;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("t5_budget", 32'(sent), 32'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("t5_drain");
        chk("t5_count", 32'(ncomp), 32'(sent));

        // Asynchronous reset while the skid is full.
        do_reset();
        out_ready = 1'b0;
        send(7, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        chk("t6_full", 32'(in_ready), 32'd0);
        chk("t6_cnt6_pre", 32'(err_cnt6), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        chk("t6_cnt", 32'(err_cnt), 32'd0);
        chk("t6_cnt6", 32'(err_cnt6), 32'd0);
        chk("t6_valid6", 32'(out_valid6), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        got8.delete(); got6.delete();
        send(4, 1'b1, 1'b1);
        wait_empty("t6_drain");
        chk("t6_count", 32'(got8.size()), 32'd1);
        if (got8.size() == 1) chk("t6_after", 32'(got8[0]), 32'h01F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
